// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if
//   Instruction-memory request/acknowledge bus between the fetch stage and
//   instruction memory.
//   imem_req   : fetch request, held high until imem_ack
//   imem_addr  : word fetch address, stable while imem_req is high
//   imem_ack   : one-cycle acknowledge; imem_rdata is valid in that cycle
//   imem_rdata : fetched instruction word
//   Modports: master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program
//   counter, fetches words over a req/ack bus and loads the IF/ID register.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     stall        : hold PC and IF/ID
//     redirect     : taken branch/jump from EX, target in redirect_pc
//     imem         : instruction-memory bus (master side)
//     pc           : current fetch PC
//     ifid_valid   : IF/ID holds a real instruction (0 = bubble)
//     ifid_instr   : IF/ID instruction word
//     ifid_pc4     : IF/ID PC+4
//     fetch_exc    : sticky misaligned-target exception
//   Parameter RESET_PC : word-aligned PC after reset.
//   Macro IF_ALIGN_CHECK_EN : when defined, a misaligned redirect target
//   raises fetch_exc and parks the stage in EXC until reset; otherwise the
//   low two target bits are forced to zero and fetch_exc is tied low.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  if_fetch_stage_if.master imem,
  output logic [31:0]      pc,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             fetch_exc
);

`ifdef IF_ALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DROP, EXC} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, instr_nxt, pc4_nxt;
  logic        valid_nxt;
  logic [31:0] hold_buf, buf_nxt;
  logic [31:0] drop_addr, drop_nxt;
  logic [31:0] target, pc_plus4;

`ifdef IF_ALIGN_CHECK_EN
  logic target_bad;
  logic exc_pending, pend_nxt;
  assign target     = redirect_pc;
  assign target_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign target = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Wraps modulo 2^32 by width.
  assign pc_plus4 = pc + 32'd4;

  // DROP keeps presenting the abandoned address until its ack arrives, while
  // pc already holds the redirect target.
  assign imem.imem_req  = (state == FETCH) || (state == DROP);
  assign imem.imem_addr = (state == DROP) ? drop_addr : pc;

`ifdef IF_ALIGN_CHECK_EN
  assign fetch_exc = (state == EXC);
`else
  assign fetch_exc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
      hold_buf   <= 32'h0;
      drop_addr  <= RESET_PC;
`ifdef IF_ALIGN_CHECK_EN
      exc_pending <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ifid_valid <= valid_nxt;
      ifid_instr <= instr_nxt;
      ifid_pc4   <= pc4_nxt;
      hold_buf   <= buf_nxt;
      drop_addr  <= drop_nxt;
`ifdef IF_ALIGN_CHECK_EN
      exc_pending <= pend_nxt;
`endif
    end
  end

  // Next state and next register values; redirect beats ack beats stall.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = ifid_valid;
    instr_nxt = ifid_instr;
    pc4_nxt   = ifid_pc4;
    buf_nxt   = hold_buf;
    drop_nxt  = drop_addr;
`ifdef IF_ALIGN_CHECK_EN
    pend_nxt  = exc_pending;
`endif
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_nxt    = target;
          valid_nxt = 1'b0;
          if (imem.imem_ack) begin
            // Coinciding ack: the word is simply dropped.
            state_nxt = FETCH;
`ifdef IF_ALIGN_CHECK_EN
            if (target_bad) state_nxt = EXC;
`endif
          end else begin
            drop_nxt  = pc;
            state_nxt = DROP;
`ifdef IF_ALIGN_CHECK_EN
            pend_nxt  = target_bad;
`endif
          end
        end else if (imem.imem_ack) begin
          if (stall) begin
            buf_nxt   = imem.imem_rdata;
            state_nxt = HOLD;
          end else begin
            valid_nxt = 1'b1;
            instr_nxt = imem.imem_rdata;
            pc4_nxt   = pc_plus4;
            pc_nxt    = pc_plus4;
          end
        end else if (!stall) begin
          valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
`ifdef IF_ALIGN_CHECK_EN
          if (target_bad) state_nxt = EXC;
`endif
        end else if (!stall) begin
          valid_nxt = 1'b1;
          instr_nxt = hold_buf;
          pc4_nxt   = pc_plus4;
          pc_nxt    = pc_plus4;
          state_nxt = FETCH;
        end
      end
      DROP: begin
        // Latest redirect wins; the stale ack only releases the bus.
        if (redirect) begin
          pc_nxt   = target;
`ifdef IF_ALIGN_CHECK_EN
          pend_nxt = target_bad;
`endif
        end
        if (imem.imem_ack) begin
          state_nxt = FETCH;
`ifdef IF_ALIGN_CHECK_EN
          if (pend_nxt) state_nxt = EXC;
`endif
        end
      end
      default: begin
      end
    endcase
  end

endmodule
